masked_rand_gen: RTL



---
 rtl/masked_rand_gen_if.sv | 23 ++
 rtl/masked_rand_gen.sv | 96 +++++++++
 2 files changed

// File: rtl/masked_rand_gen_if.sv
// Seed and fresh-mask handshake bundle between the mask generator and its users.
// master = generator side, slave = seeder/consumer side.
interface masked_rand_gen_if #(
    parameter int RW = 36
);
    logic [63:0]   seed;
    logic          seed_valid;
    logic          seed_ready;
    logic [RW-1:0] r;
    logic          r_valid;
    logic          r_ready;
    logic          reseed_req;

    modport master (
        input  seed, seed_valid, r_ready,
        output seed_ready, r, r_valid, reseed_req
    );

    modport slave (
        output seed, seed_valid, r_ready,
        input  seed_ready, r, r_valid, reseed_req
    );
endinterface

// File: rtl/masked_rand_gen.sv
// Fresh-mask source for the 3-share masked GF(16) multiplier: a 64-bit LFSR advanced
// RW steps per delivered word, with seeding, warm-up and a reseed budget.
module masked_rand_gen #(
    parameter int RW              = 36,
    parameter int WARMUP          = 4,
    parameter int RESEED_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst,
    masked_rand_gen_if.master bus
);
    localparam int              WCW       = $clog2(RESEED_INTERVAL + 1);
    localparam logic [WCW-1:0]  WORD_MAX  = WCW'(RESEED_INTERVAL);
    localparam logic [3:0]      WARM_LAST = 4'(WARMUP - 1);

    typedef enum logic [1:0] {IDLE, WARM, RUN} fsm_t;

    fsm_t           fsm;
    fsm_t           fsm_nxt;
    logic [63:0]    lfsr;
    logic [3:0]     warm_cnt;
    logic [WCW-1:0] word_cnt;
    logic           reseed;
    logic           seed_acc;
    logic           take;

    // RW single steps of x^64+x^63+x^61+x^60+1, unrolled into one cycle.
    function automatic logic [63:0] word_step(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < RW; i++) begin
            t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
        end
        return t;
    endfunction

    assign seed_acc = bus.seed_valid;
    // A seed in the same cycle as a handshake wins; that word is simply never counted.
    assign take     = (fsm == RUN) && bus.r_ready && !seed_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        if (seed_acc) begin
            fsm_nxt = WARM;
        end else begin
            case (fsm)
                WARM:    if (warm_cnt == WARM_LAST) fsm_nxt = RUN;
                default: fsm_nxt = fsm;
            endcase
        end
    end

    always_comb begin
        bus.seed_ready = 1'b1;
        bus.r_valid    = (fsm == RUN);
        bus.r          = lfsr[RW-1:0];
        bus.reseed_req = reseed;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= '0;
            warm_cnt <= '0;
            word_cnt <= '0;
            reseed   <= 1'b0;
        end else if (seed_acc) begin
            // An all-zero seed would lock the LFSR at zero forever.
            lfsr     <= (bus.seed == 64'h0) ? 64'h1 : bus.seed;
            warm_cnt <= '0;
            word_cnt <= '0;
            reseed   <= 1'b0;
        end else begin
            if (fsm == WARM) begin
                lfsr     <= word_step(lfsr);
                warm_cnt <= warm_cnt + 4'd1;
            end
            if (take) begin
                lfsr <= word_step(lfsr);
                if (word_cnt != WORD_MAX) begin
                    word_cnt <= word_cnt + 1'b1;
                end
                if (word_cnt == WORD_MAX - 1'b1) begin
                    reseed <= 1'b1;
                end
            end
        end
    end
endmodule
